pixel_write_arbiter: RTL
========================

Name: pixel_write_arbiter

Overview:
Downstream stage of the per-car and per-tower datapaths. It merges their pixel streams (x, y, colour) into the single write port of the VGA adapter. Sources are served round-robin. A source keeps ownership for a whole sprite burst, so draw/erase sequences never interleave on screen. The owner releases when its request drops or when it hits a burst cap, which prevents starvation.

Parameters:
N_SRC, 4, number of pixel sources (2..8)
MAX_BURST, 64, max pixels accepted per ownership; 0 = unlimited

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
src_req  in  N_SRC  per-source request; a source holds it high while it has a valid pixel
src_x  in  8*N_SRC  packed x; source i at [8i+7:8i]
src_y  in  7*N_SRC  packed y; source i at [7i+6:7i]
src_colour  in  9*N_SRC  packed colour; source i at [9i+8:9i]
src_grant  out  N_SRC  one-hot; high means the source's pixel is consumed this cycle and it must present the next one
vga_x  out  8  registered x to adapter
vga_y  out  7  registered y to adapter
vga_colour  out  9  registered colour
vga_plot  out  1  registered write strobe
busy  out  1  high while in OWN
owner  out  3  index of current or last owner

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (including mid-burst) forces:
  - vga_x, vga_y, vga_colour, vga_plot, busy, owner, burst counter all to 0
  - state to IDLE
  - round-robin pointer to N_SRC-1, so source 0 has first priority
- States: IDLE, OWN.
- IDLE:
  - src_grant = 0.
  - If any src_req is high, pick the first requester searching upward from pointer+1, with wrap-around.
  - Load owner with that index, clear the burst counter, go to OWN.
  - If no request, stay in IDLE.
  - One dead cycle always separates ownerships.
- OWN:
  - src_grant[owner] = src_req[owner], combinational. All other grants are 0.
  - On a grant cycle, capture the owner's x/y/colour into the vga_* registers and set vga_plot=1 on the next edge. Latency is exactly 1 cycle.
  - On a non-grant cycle, vga_plot=0 and vga_x/vga_y/vga_colour hold their values.
  - The burst counter increments per grant.
- Release from OWN to IDLE:
  - when src_req[owner] is low (no grant that cycle), or
  - when MAX_BURST≠0 and the grant just issued is the MAX_BURST-th.
  - On release, pointer ← owner. The next search starts at owner+1.
- Requests from non-owners in OWN are ignored; those sources must hold req until granted.
- At most one grant per cycle, so vga_plot rate ≤ 1 pixel/cycle.
- The burst counter is $clog2(MAX_BURST+1) bits wide and saturates, with no wrap.
- busy = (state==OWN).
- A source whose burst is cut off by the cap keeps req high and re-arbitrates fairly. Its sprite may then interleave; that is accepted.

Optional Feature:
Macro PIXEL_CLIP_EN.
- Defined: a granted pixel with x≥160 or y≥120 is still granted (consumed) and still counts toward the burst, but vga_plot stays 0 for it.
- Not defined: every granted pixel is plotted unchanged. Out-of-range handling is left to the adapter.

Decomposition:
- Package vga_pkg holds X_W=8, Y_W=7, COLOUR_W=9, SCREEN_W=160, SCREEN_H=120, and the IDLE/OWN state enum.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: valid, index.
  - Instanced once.

Test Plan:
- src0 holds req for 3 pixels (10,60,0x1FF),(11,60,0x1FF),(12,60,0x000), then drops → src_grant[0] high for 3 cycles starting the cycle after req; vga_plot high 3 cycles, each 1 cycle after its grant, with matching data; return to IDLE, busy=0.
- src1 and src3 request together from reset → src1 served first. src3 is granted only after src1 drops req plus one IDLE cycle; owner=3 then.
- MAX_BURST=4, src0 streams 10 pixels while src2 also requests → src0 gets 4 grants; IDLE; src2 served; src0 resumes afterwards with pixel 5.
- reset asserted on the 2nd cycle of a burst → next cycle: vga_plot=0, src_grant=0, busy=0, owner=0; a fresh req on src2 is granted after IDLE arbitration.
- PIXEL_CLIP_EN defined, pixels (159,119) then (160,5) → both granted; vga_plot=1 only for (159,119). Without the macro, both are plotted.
- Idle streams: all req low for 20 cycles → no grants; vga_plot=0; vga_x/vga_y/vga_colour hold their last values.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA pixel path: field widths of the adapter write
// port, visible screen size, and the state type of the pixel write arbiter.
// No ports (package).
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 9;

  // Visible area; typed to the coordinate widths so compares stay width-clean.
  localparam logic [X_W-1:0] SCREEN_W = 8'd160;
  localparam logic [Y_W-1:0] SCREEN_H = 7'd120;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first asserted request found
// searching upward from ptr_i+1 with wrap-around (ptr_i itself is checked last).
// Ports:
//   req_i   [N_SRC-1:0]  request vector
//   ptr_i   [IDX_W-1:0]  index of the most recently served source
//   valid_o              at least one request is asserted
//   idx_o   [IDX_W-1:0]  index of the chosen request (0 when !valid_o)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N_SRC = 4,
  parameter int IDX_W = 3
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Outer loop walks the search distance; the first hit locks the result.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!valid_o && req_i[i] && (((int'(ptr_i) + k) % N_SRC) == i)) begin
          valid_o = 1'b1;
          idx_o   = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// ---------------------------------------------------------------------------
// pixel_write_arbiter
// Merges N_SRC pixel streams into the single VGA adapter write port. Sources
// are served round-robin; the owner keeps the port for a whole burst until
// its request drops or MAX_BURST pixels have been taken (0 = no cap). One
// IDLE cycle always separates two ownerships.
//
// Handshake: src_req[i] high means source i presents a valid pixel. In OWN,
// src_grant[owner] = src_req[owner] combinationally; a grant means that pixel
// is consumed at this clock edge and the source must present its next pixel
// (or drop req). Non-owners must hold req until they are granted.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   src_req   [N]         per-source request
//   src_x     [8N]        packed x, source i at [8i+7:8i]
//   src_y     [7N]        packed y, source i at [7i+6:7i]
//   src_colour[9N]        packed colour, source i at [9i+8:9i]
//   src_grant [N]         one-hot consume strobe
//   vga_x/vga_y/vga_colour/vga_plot  registered adapter write port
//   busy                  high while a source owns the port (state OWN)
//   owner     [3]         index of current or last owner
//
// Optional build macro PIXEL_CLIP_EN: granted pixels outside the 160x120
// screen are consumed and counted but not plotted.
// ---------------------------------------------------------------------------
module pixel_write_arbiter
  import vga_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int MAX_BURST = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_SRC-1:0]          src_req,
  input  logic [X_W*N_SRC-1:0]      src_x,
  input  logic [Y_W*N_SRC-1:0]      src_y,
  input  logic [COLOUR_W*N_SRC-1:0] src_colour,
  output logic [N_SRC-1:0]          src_grant,
  output logic [X_W-1:0]            vga_x,
  output logic [Y_W-1:0]            vga_y,
  output logic [COLOUR_W-1:0]       vga_colour,
  output logic                      vga_plot,
  output logic                      busy,
  output logic [2:0]                owner
);

  // With no cap the counter is never consulted; keep it one bit wide.
  localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e           state_q, state_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [2:0]           owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [X_W-1:0]       vga_x_q, vga_x_d;
  logic [Y_W-1:0]       vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0]  vga_col_q, vga_col_d;
  logic                 plot_q, plot_d;

  logic                 pick_valid;
  logic [2:0]           pick_idx;

  logic                 own_req;
  logic [X_W-1:0]       own_x;
  logic [Y_W-1:0]       own_y;
  logic [COLOUR_W-1:0]  own_col;

  rr_pick #(
    .N_SRC (N_SRC),
    .IDX_W (3)
  ) u_rr_pick (
    .req_i   (src_req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Select the current owner's request and pixel.
  always_comb begin
    own_req = 1'b0;
    own_x   = '0;
    own_y   = '0;
    own_col = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (owner_q == 3'(i)) begin
        own_req = src_req[i];
        own_x   = src_x[X_W*i +: X_W];
        own_y   = src_y[Y_W*i +: Y_W];
        own_col = src_colour[COLOUR_W*i +: COLOUR_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    vga_x_d   = vga_x_q;
    vga_y_d   = vga_y_q;
    vga_col_d = vga_col_q;
    plot_d    = 1'b0;
    src_grant = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = ST_OWN;
        end
      end

      ST_OWN: begin
        if (own_req) begin
          for (int i = 0; i < N_SRC; i++) begin
            if (owner_q == 3'(i)) src_grant[i] = 1'b1;
          end
          vga_x_d   = own_x;
          vga_y_d   = own_y;
          vga_col_d = own_col;
`ifdef PIXEL_CLIP_EN
          plot_d    = (own_x < SCREEN_W) && (own_y < SCREEN_H);
`else
          plot_d    = 1'b1;
`endif
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          // This grant is the MAX_BURST-th of the ownership: hand the port on.
          if ((MAX_BURST != 0) && (cnt_q == CNT_LAST)) begin
            state_d = ST_IDLE;
            ptr_d   = owner_q;
          end
        end else begin
          state_d = ST_IDLE;
          ptr_d   = owner_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 3'(N_SRC - 1);
      owner_q   <= '0;
      cnt_q     <= '0;
      vga_x_q   <= '0;
      vga_y_q   <= '0;
      vga_col_q <= '0;
      plot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      vga_x_q   <= vga_x_d;
      vga_y_q   <= vga_y_d;
      vga_col_q <= vga_col_d;
      plot_q    <= plot_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_col_q;
  assign vga_plot   = plot_q;
  assign busy       = (state_q == ST_OWN);
  assign owner      = owner_q;

endmodule
